lfsr_prbs_err_count: RTL and testbench

Error accumulator and lock monitor placed directly downstream of lfsr_prbs_check. It consumes the per-bit error vector (data_out of the checker, where 1 = mismatched bit) and a matching valid strobe. Per word it computes a pipelined popcount and runs a HUNT/SYNC/LOCKED lock state machine. While locked it accumulates saturating bit-error and bit-checked counters, and supports atomic snapshot and read-and-clear for BER readout by a CSR block.

---
 rtl/lfsr_prbs_err_count.sv | 185 ++++++++++++++++++
 tb/tb_lfsr_prbs_err_count.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_err_count.sv
// lfsr_prbs_err_count: error accumulator and lock monitor fed by lfsr_prbs_check.
// The design is a two-stage pipeline:
//   - Stage 1 registers the popcount of err_in together with its valid strobe.
//   - Stage 2 runs the HUNT/SYNC/LOCKED state machine and the saturating BER counters.
// Optional feature macro: PRBS_ERR_LOCK_LOSS_EN enables the lock_loss_count counter.
module lfsr_prbs_err_count #(
  parameter int DATA_WIDTH   = 64,
  parameter int COUNT_WIDTH  = 48,
  parameter int LOCK_COUNT   = 16,
  parameter int BAD_THRESH   = 8,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  err_in,
  input  logic                   err_in_valid,
  input  logic                   clear,
  input  logic                   snap,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic [COUNT_WIDTH-1:0] bit_count,
  output logic [COUNT_WIDTH-1:0] err_snap,
  output logic [COUNT_WIDTH-1:0] bit_snap,
  output logic                   sat,
  output logic [15:0]            lock_loss_count
);

  localparam int PW = $clog2(DATA_WIDTH + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int SW = COUNT_WIDTH + 1;

  localparam logic [PW-1:0] BAD_T    = PW'(BAD_THRESH);
  localparam logic [GW-1:0] LOCK_T   = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] UNLOCK_T = BW'(UNLOCK_COUNT);
  localparam logic [SW-1:0] WORD_INC = SW'(DATA_WIDTH);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t                 r_state;
  logic [PW-1:0]          r_pop;
  logic                   r_v1;
  logic [GW-1:0]          r_good_run;
  logic [BW-1:0]          r_bad_run;
  logic [COUNT_WIDTH-1:0] r_err_count;
  logic [COUNT_WIDTH-1:0] r_bit_count;
  logic [COUNT_WIDTH-1:0] r_err_snap;
  logic [COUNT_WIDTH-1:0] r_bit_snap;
  logic                   r_sat;

  logic [PW-1:0] w_pop;
  logic          w_clean;
  logic          w_bad;
  logic          w_accum;
  logic          w_unlock;
  logic [SW-1:0] w_err_sum;
  logic [SW-1:0] w_bit_sum;

  // Combinational popcount of the incoming error vector
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      w_pop = w_pop + PW'(err_in[i]);
    end
  end

  assign w_clean   = (r_pop == '0);
  assign w_bad     = (r_pop > BAD_T);
  assign w_accum   = r_v1 && (r_state == LOCKED);
  assign w_unlock  = w_accum && w_bad && ((r_bad_run + BW'(1)) == UNLOCK_T);
  assign w_err_sum = {1'b0, r_err_count} + SW'(r_pop);
  assign w_bit_sum = {1'b0, r_bit_count} + WORD_INC;

  // Stage 1: register popcount and its valid; reset drops any in-flight word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop <= '0;
      r_v1  <= 1'b0;
    end else begin
      r_v1 <= err_in_valid;
      if (err_in_valid) begin
        r_pop <= w_pop;
      end
    end
  end

  // Stage 2: lock state machine; only valid words advance state or run counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_good_run <= '0;
      r_bad_run  <= '0;
    end else if (r_v1) begin
      unique case (r_state)
        HUNT: begin
          if (w_clean) begin
            r_good_run <= GW'(1);
            r_state    <= (LOCK_COUNT == 1) ? LOCKED : SYNC;
            r_bad_run  <= '0;
          end
        end
        SYNC: begin
          if (!w_clean) begin
            r_state    <= HUNT;
            r_good_run <= '0;
          end else if ((r_good_run + GW'(1)) == LOCK_T) begin
            r_state    <= LOCKED;
            r_good_run <= '0;
            r_bad_run  <= '0;
          end else begin
            r_good_run <= r_good_run + GW'(1);
          end
        end
        LOCKED: begin
          if (!w_bad) begin
            r_bad_run <= '0;
          end else if (w_unlock) begin
            r_state    <= HUNT;
            r_bad_run  <= '0;
            r_good_run <= '0;
          end else begin
            r_bad_run <= r_bad_run + BW'(1);
          end
        end
        default: begin
          r_state <= HUNT;
        end
      endcase
    end
  end

  // Stage 2: saturating counters; snapshot takes pre-edge values, clear beats accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
      r_bit_count <= '0;
      r_err_snap  <= '0;
      r_bit_snap  <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (snap) begin
        r_err_snap <= r_err_count;
        r_bit_snap <= r_bit_count;
      end
      if (clear) begin
        r_err_count <= '0;
        r_bit_count <= '0;
        r_sat       <= 1'b0;
      end else if (w_accum) begin
        r_err_count <= w_err_sum[COUNT_WIDTH] ? '1 : w_err_sum[COUNT_WIDTH-1:0];
        r_bit_count <= w_bit_sum[COUNT_WIDTH] ? '1 : w_bit_sum[COUNT_WIDTH-1:0];
        if (w_err_sum[COUNT_WIDTH] || w_bit_sum[COUNT_WIDTH]) begin
          r_sat <= 1'b1;
        end
      end
    end
  end

`ifdef PRBS_ERR_LOCK_LOSS_EN
  logic [15:0] r_lock_loss;

  // Saturating count of LOCKED->HUNT transitions; clear on the same edge wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_loss <= '0;
    end else if (clear) begin
      r_lock_loss <= '0;
    end else if (w_unlock && (r_lock_loss != '1)) begin
      r_lock_loss <= r_lock_loss + 16'd1;
    end
  end

  assign lock_loss_count = r_lock_loss;
`else
  assign lock_loss_count = '0;
`endif

  assign locked    = (r_state == LOCKED);
  assign err_count = r_err_count;
  assign bit_count = r_bit_count;
  assign err_snap  = r_err_snap;
  assign bit_snap  = r_bit_snap;
  assign sat       = r_sat;

endmodule

// File: tb/tb_lfsr_prbs_err_count.sv
// Directed testbench for lfsr_prbs_err_count.
// Two instances share the same stimulus:
//   - u_dut uses the default parameters.
//   - u_dut8 uses 8-bit counters so that saturation can be reached.
module tb_lfsr_prbs_err_count;

`ifdef PRBS_ERR_LOCK_LOSS_EN
  localparam int LL = 1;
`else
  localparam int LL = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [63:0] err_in;
  logic        err_in_valid;
  logic        clear;
  logic        snap;

  logic        locked;
  logic [47:0] err_count, bit_count, err_snap, bit_snap;
  logic        sat;
  logic [15:0] lock_loss_count;

  logic        b_locked;
  logic [7:0]  b_err_count, b_bit_count, b_err_snap, b_bit_snap;
  logic        b_sat;
  logic [15:0] b_lock_loss_count;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_prbs_err_count #(
    .DATA_WIDTH(64), .COUNT_WIDTH(48), .LOCK_COUNT(16), .BAD_THRESH(8), .UNLOCK_COUNT(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .err_in(err_in), .err_in_valid(err_in_valid),
    .clear(clear), .snap(snap), .locked(locked), .err_count(err_count),
    .bit_count(bit_count), .err_snap(err_snap), .bit_snap(bit_snap),
    .sat(sat), .lock_loss_count(lock_loss_count)
  );

  lfsr_prbs_err_count #(
    .DATA_WIDTH(64), .COUNT_WIDTH(8), .LOCK_COUNT(16), .BAD_THRESH(8), .UNLOCK_COUNT(4)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .err_in(err_in), .err_in_valid(err_in_valid),
    .clear(clear), .snap(snap), .locked(b_locked), .err_count(b_err_count),
    .bit_count(b_bit_count), .err_snap(b_err_snap), .bit_snap(b_bit_snap),
    .sat(b_sat), .lock_loss_count(b_lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        clr;
    logic [63:0] pat;
    int          n;
    logic        exp_locked;
    logic [47:0] exp_err;
    logic [47:0] exp_bit;
    int          exp_ll;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge
  task automatic step(input logic [63:0] w, input logic v, input logic c, input logic s);
    err_in       = w;
    err_in_valid = v;
    clear        = c;
    snap         = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(64'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{"lock_3err",   1'b0, 64'h7,   10, 1'b1, 48'd30,  48'd640, 0};
    tbl[1] = '{"unlock_9err", 1'b1, 64'h1FF,  4, 1'b0, 48'd36,  48'd256, 1};
    tbl[2] = '{"hunt_margin", 1'b0, 64'h1,    5, 1'b0, 48'd36,  48'd256, 1};
    tbl[3] = '{"relock",      1'b1, 64'h0,   16, 1'b1, 48'd0,   48'd0,   0};
    tbl[4] = '{"margin_pop8", 1'b0, 64'hFF,   6, 1'b1, 48'd48,  48'd384, 0};
    tbl[5] = '{"bad_x3",      1'b0, 64'h1FF,  3, 1'b1, 48'd75,  48'd576, 0};
    tbl[6] = '{"clean_rst",   1'b0, 64'h0,    1, 1'b1, 48'd75,  48'd640, 0};
    tbl[7] = '{"bad_x3_b",    1'b0, 64'h1FF,  3, 1'b1, 48'd102, 48'd832, 0};
    tbl[8] = '{"bad_4th",     1'b0, 64'h1FF,  1, 1'b0, 48'd111, 48'd896, 1};

    rst_n = 1'b0;
    err_in = '0; err_in_valid = 1'b0; clear = 1'b0; snap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", {63'd0, locked}, 64'd0);
    chk("rst_err", {16'd0, err_count}, 64'd0);
    chk("rst_bit", {16'd0, bit_count}, 64'd0);
    chk("rst_sat", {63'd0, sat}, 64'd0);
    chk("rst_snap", {16'd0, err_snap | bit_snap}, 64'd0);
    chk("rst_ll", {48'd0, lock_loss_count}, 64'd0);
    rst_n = 1'b1;
    idle();

    // 16 clean words: locked must rise exactly 2 clocks after the 16th
    for (int i = 0; i < 16; i++) step(64'h0, 1'b1, 1'b0, 1'b0);
    chk("lock_lat_1clk", {63'd0, locked}, 64'd0);
    idle();
    chk("lock_lat_2clk", {63'd0, locked}, 64'd1);
    idle();
    chk("lock_err0", {16'd0, err_count}, 64'd0);
    chk("lock_bit0", {16'd0, bit_count}, 64'd0);

    for (int t = 0; t < 9; t++) begin
      if (tbl[t].clr) step(64'h0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < tbl[t].n; k++) step(tbl[t].pat, 1'b1, 1'b0, 1'b0);
      idle();
      idle();
      chk({tbl[t].name, "_locked"}, {63'd0, locked}, {63'd0, tbl[t].exp_locked});
      chk({tbl[t].name, "_err"}, {16'd0, err_count}, {16'd0, tbl[t].exp_err});
      chk({tbl[t].name, "_bit"}, {16'd0, bit_count}, {16'd0, tbl[t].exp_bit});
      chk({tbl[t].name, "_ll"}, {48'd0, lock_loss_count}, 64'(tbl[t].exp_ll * LL));
      chk({tbl[t].name, "_sat"}, {63'd0, sat}, 64'd0);
    end

    // SYNC broken by a 1-error word after 10 clean words; 16 more clean words needed
    for (int i = 0; i < 10; i++) step(64'h0, 1'b1, 1'b0, 1'b0);
    step(64'h10, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(64'h0, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("sync_break_15", {63'd0, locked}, 64'd0);
    step(64'h0, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("sync_break_16", {63'd0, locked}, 64'd1);
    chk("sync_err_hold", {16'd0, err_count}, 64'd111);

    // Atomic read-and-clear: snap+clear coincide with stage 2 of a 2-error word
    step(64'h0, 1'b0, 1'b1, 1'b0);
    step(64'h1F, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("pre_snap_err", {16'd0, err_count}, 64'd5);
    step(64'h3, 1'b1, 1'b0, 1'b0);
    step(64'h0, 1'b0, 1'b1, 1'b1);
    chk("snap_err", {16'd0, err_snap}, 64'd5);
    chk("snap_bit", {16'd0, bit_snap}, 64'd64);
    chk("snap_b_err", {56'd0, b_err_snap}, 64'd5);
    chk("clr_err", {16'd0, err_count}, 64'd0);
    chk("clr_bit", {16'd0, bit_count}, 64'd0);
    idle();
    chk("clr_drop_err", {16'd0, err_count}, 64'd0);
    chk("clr_locked", {63'd0, locked}, 64'd1);

    // Saturation on the 8-bit instance: 4 counted words of 64 errors, 5th after unlock
    step(64'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step('1, 1'b1, 1'b0, 1'b0);
    chk("unlock_pre_locked", {63'd0, locked}, 64'd1);
    chk("sat_pre_err", {56'd0, b_err_count}, 64'd192);
    chk("sat_pre_flag", {63'd0, b_sat}, 64'd0);
    step('1, 1'b1, 1'b0, 1'b0);
    chk("unlock_post_locked", {63'd0, locked}, 64'd0);
    idle();
    idle();
    chk("sat_err", {56'd0, b_err_count}, 64'd255);
    chk("sat_bit", {56'd0, b_bit_count}, 64'd255);
    chk("sat_flag", {63'd0, b_sat}, 64'd1);
    chk("sat_main_err", {16'd0, err_count}, 64'd256);
    chk("sat_main_flag", {63'd0, sat}, 64'd0);
    chk("sat_ll", {48'd0, lock_loss_count}, 64'(LL));
    chk("sat_b_ll", {48'd0, b_lock_loss_count}, 64'(LL));
    step(64'h0, 1'b0, 1'b1, 1'b0);
    chk("sat_clr_err", {56'd0, b_err_count}, 64'd0);
    chk("sat_clr_bit", {56'd0, b_bit_count}, 64'd0);
    chk("sat_clr_flag", {63'd0, b_sat}, 64'd0);
    chk("sat_clr_locked", {63'd0, b_locked}, 64'd0);
    chk("sat_clr_bsnap", {56'd0, b_bit_snap}, 64'd64);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
